// File: rtl/input_cond_pkg.sv
// Shared definitions for the board input conditioning blocks.
//   - debouncer state encodings (2 bits, kept stable for legacy decode)
//   - default qualification length for push-button debouncing
package input_cond_pkg;

  typedef logic [1:0] db_state_t;

  localparam db_state_t IDLE_LOW   = 2'b00;
  localparam db_state_t CHECK_HIGH = 2'b01;
  localparam db_state_t IDLE_HIGH  = 2'b10;
  localparam db_state_t CHECK_LOW  = 2'b11;

  // 10 ms at a 100 MHz clk
  localparam int DEFAULT_STABLE_CYCLES = 1_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous board inputs.
// Ports:
//   clk    - destination clock
//   rst    - synchronous active-low reset, clears both stages
//   d      - asynchronous input
//   q      - synchronized output (second stage)
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_q1;
  logic [WIDTH-1:0] sync_q2;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= d;
      sync_q2 <= sync_q1;
    end
  end

  assign q = sync_q2;

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer: synchronizes a raw bouncing button and accepts a
// level change only after STABLE_CYCLES consecutive identical samples.
// Ports:
//   clk      - system clock
//   rst      - synchronous active-low reset
//   btn_in   - raw asynchronous button level
//   db_out   - debounced level (feeds the rising-edge detector w input)
//   bouncing - high while a candidate level change is being qualified
//
// state      | meaning
// IDLE_LOW   | debounced low, waiting for a high sample
// CHECK_HIGH | qualifying a low->high change, cnt = samples seen high
// IDLE_HIGH  | debounced high, waiting for a low sample
// CHECK_LOW  | qualifying a high->low change, cnt = samples seen low
import input_cond_pkg::*;

module button_debouncer #(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic db_out,
  output logic bouncing
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync_q2;
  db_state_t        state;
  logic [CNT_W-1:0] cnt;

  sync_2ff #(
    .WIDTH (1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (sync_q2)
  );

  // The first differing sample already counts as one, so the terminal
  // compare at STABLE_CYCLES-1 completes on the STABLE_CYCLES-th sample.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE_LOW;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE_LOW: begin
          if (sync_q2) begin
            state <= CHECK_HIGH;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= '0;
          end
        end
        CHECK_HIGH: begin
          if (!sync_q2) begin
            state <= IDLE_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE_HIGH;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        IDLE_HIGH: begin
          if (!sync_q2) begin
            state <= CHECK_LOW;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= '0;
          end
        end
        CHECK_LOW: begin
          if (sync_q2) begin
            state <= IDLE_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE_LOW;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign db_out   = (state == IDLE_HIGH)  || (state == CHECK_LOW);
  assign bouncing = (state == CHECK_HIGH) || (state == CHECK_LOW);

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with STABLE_CYCLES = 4.
// A run-length model of the debounce rule is checked on every negedge;
// literal expectations at key edges pin the model.
module tb_button_debouncer;

  localparam int S = 4;

  logic clk;
  logic rst;
  logic btn_in;
  logic db_out;
  logic bouncing;

  int n_checks = 0;
  int n_fail   = 0;

  button_debouncer #(
    .STABLE_CYCLES (S)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_in   (btn_in),
    .db_out   (db_out),
    .bouncing (bouncing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the debouncer sees the button two edges late; a level change is
  // accepted once S consecutive seen samples disagree with the current level.
  logic m_q1 = 1'b0;
  logic m_q2 = 1'b0;
  logic m_db = 1'b0;
  int   m_run = 0;
  bit   m_valid = 1'b0;

  always @(posedge clk) begin
    logic seen;
    if (!rst) begin
      m_q1 = 1'b0;
      m_q2 = 1'b0;
      m_db = 1'b0;
      m_run = 0;
      m_valid = 1'b1;
    end else begin
      seen = m_q2;
      m_q2 = m_q1;
      m_q1 = btn_in;
      if (seen != m_db) begin
        m_run++;
        if (m_run == S) begin
          m_db = ~m_db;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end
  end

  int   rises = 0;
  logic prev_db = 1'b0;

  always @(negedge clk) begin
    if (m_valid) begin
      check_bit("model_db_out", db_out, m_db);
      check_bit("model_bouncing", bouncing, m_run > 0);
      if (db_out === 1'b1 && prev_db === 1'b0) rises++;
      prev_db = db_out;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   r0;
    logic saw_bounce;
    logic pat [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    rst = 1'b0;
    btn_in = 1'b1;

    // reset held with button high
    repeat (3) begin
      tick();
      check_bit("rst_db_out", db_out, 1'b0);
      check_bit("rst_bouncing", bouncing, 1'b0);
    end
    rst = 1'b1;
    repeat (5) tick();
    check_bit("rst_release_pre", db_out, 1'b0);
    tick();
    check_bit("rst_release_rise", db_out, 1'b1);

    // release
    btn_in = 1'b0;
    repeat (5) tick();
    check_bit("release_pre", db_out, 1'b1);
    tick();
    check_bit("release_fall", db_out, 1'b0);
    check_bit("release_bouncing", bouncing, 1'b0);
    repeat (3) tick();

    // clean press
    btn_in = 1'b1;
    tick();
    tick();
    check_bit("press_bouncing_early", bouncing, 1'b0);
    tick();
    check_bit("press_bouncing_rise", bouncing, 1'b1);
    check_bit("press_db_low", db_out, 1'b0);
    tick();
    tick();
    check_bit("press_db_pre", db_out, 1'b0);
    tick();
    check_bit("press_db_rise", db_out, 1'b1);
    check_bit("press_bouncing_fall", bouncing, 1'b0);
    btn_in = 1'b0;
    repeat (6) tick();
    check_bit("press_release_fall", db_out, 1'b0);
    repeat (2) tick();

    // bounce rejection: 3 high, 1 low, 3 high, then low
    saw_bounce = 1'b0;
    foreach (pat[i]) begin
      btn_in = pat[i];
      tick();
      check_bit("reject_db_low", db_out, 1'b0);
      saw_bounce = saw_bounce | bouncing;
    end
    repeat (8) begin
      tick();
      saw_bounce = saw_bounce | bouncing;
    end
    check_bit("reject_saw_bouncing", saw_bounce, 1'b1);
    check_bit("reject_db_end", db_out, 1'b0);
    check_bit("reject_bouncing_end", bouncing, 1'b0);

    // bounce then settle, then bouncy release: exactly one rise
    r0 = rises;
    btn_in = 1'b1;
    tick();
    tick();
    btn_in = 1'b0;
    tick();
    btn_in = 1'b1;
    repeat (5) tick();
    check_bit("settle_db_pre", db_out, 1'b0);
    tick();
    check_bit("settle_db_rise", db_out, 1'b1);
    btn_in = 1'b0;
    tick();
    btn_in = 1'b1;
    tick();
    btn_in = 1'b0;
    repeat (5) tick();
    check_bit("settle_release_pre", db_out, 1'b1);
    tick();
    check_bit("settle_release_fall", db_out, 1'b0);
    tick();
    check("one_rise_per_press", rises - r0, 1);
    repeat (2) tick();

    // reset in the middle of CHECK_HIGH
    btn_in = 1'b1;
    repeat (4) tick();
    check_bit("midchk_bouncing", bouncing, 1'b1);
    check("midchk_cnt", int'(dut.cnt), 2);
    rst = 1'b0;
    tick();
    check_bit("midchk_rst_db", db_out, 1'b0);
    check_bit("midchk_rst_bouncing", bouncing, 1'b0);
    check("midchk_rst_cnt", int'(dut.cnt), 0);
    check("midchk_rst_state", int'(dut.state), 0);
    rst = 1'b1;
    repeat (5) tick();
    check_bit("midchk_requal_pre", db_out, 1'b0);
    tick();
    check_bit("midchk_requal_rise", db_out, 1'b1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Conditions a raw, asynchronous, bouncing push-button input into a clean, clock-synchronous level. Drives the `w` input of the rising-edge detector, which turns each debounced press into a single-cycle pulse. Contains a two-flop synchronizer, a four-state Moore FSM and a stability counter. A level change is accepted only after the synchronized input has held its new value for `STABLE_CYCLES` consecutive clocks.

## Interface
Parameters:
- `STABLE_CYCLES`, default 1_000_000. Number of consecutive identical synchronized samples required to accept a level change (10 ms at 100 MHz). Legal range is ≥ 2.
- `CNT_W`, default `$clog2(STABLE_CYCLES)`. Counter width. Derived; do not override.

Ports:
- `clk` input, 1 bit. Single clock; all state changes on its rising edge.
- `rst` input, 1 bit. Synchronous, active-low reset: sampled on the `clk` rising edge, and resets the block when 0.
- `btn_in` input, 1 bit. Raw button level, asynchronous to `clk`, may bounce.
- `db_out` output, 1 bit. Debounced level; feeds the edge detector's `w`.
- `bouncing` output, 1 bit. High while a candidate level change is being qualified.

## Operation
Synchronizer:
- `sync_q1 <= btn_in`, then `sync_q2 <= sync_q1`.
- Only `sync_q2` is used downstream.

FSM states:
- `IDLE_LOW`
- `CHECK_HIGH`
- `IDLE_HIGH`
- `CHECK_LOW`

Counter: `cnt`, `CNT_W` bits.

Transitions (evaluated each edge while `rst`=1):
- `IDLE_LOW`: if `sync_q2`=1, go to `CHECK_HIGH` with `cnt`<=1. Otherwise stay, `cnt`<=0.
- `CHECK_HIGH`:
  - If `sync_q2`=0 (bounce), go to `IDLE_LOW` with `cnt`<=0.
  - Else if `cnt`==`STABLE_CYCLES`-1, go to `IDLE_HIGH` with `cnt`<=0.
  - Else `cnt`<=`cnt`+1.
- `IDLE_HIGH`: if `sync_q2`=0, go to `CHECK_LOW` with `cnt`<=1. Otherwise stay.
- `CHECK_LOW`: mirror image of `CHECK_HIGH`.
  - A 1 sample (bounce) returns to `IDLE_HIGH`.
  - Reaching the count goes to `IDLE_LOW`.

Outputs (Moore, decoded from the registered state only, no combinational path from `btn_in`):
- `db_out` = 1 in `IDLE_HIGH` or `CHECK_LOW`.
- `bouncing` = 1 in `CHECK_HIGH` or `CHECK_LOW`.

Counter rules:
- `cnt` never exceeds `STABLE_CYCLES`-1, so no wrap-around is possible.
- `cnt` is cleared on every return to an IDLE state.

Any single opposite sample during CHECK restarts qualification from zero. Partial counts are never retained.

## Timing
Reset values (after any clock edge with `rst`=0):
- `sync_q1`=0, `sync_q2`=0.
- State `IDLE_LOW`, `cnt`=0.
- `db_out`=0, `bouncing`=0.

Reset mid-qualification:
- Discards the count.
- A button held high through reset is re-qualified from scratch after release: full latency, counted from the first edge with `rst`=1.

Latency:
- `btn_in` changes before edge k and is then stable.
- `sync_q2` reflects the change after edge k+1.
- The FSM enters CHECK at edge k+2.
- `db_out` changes after edge k+1+`STABLE_CYCLES`, i.e. `STABLE_CYCLES`+2 clocks after the input settles.
- `bouncing` rises after edge k+2 and falls together with the `db_out` change.

Pulse rejection:
- A pulse whose synchronized width is < `STABLE_CYCLES` cycles never changes `db_out`.
- A glitch narrower than one clock may be missed entirely by the synchronizer; this is acceptable.

No simultaneous-event ambiguity: the FSM has a single input.

## Structure
- Shared package/include `input_cond_pkg` holds:
  - the 2-bit state encodings (`IDLE_LOW`=2'b00, `CHECK_HIGH`=2'b01, `IDLE_HIGH`=2'b10, `CHECK_LOW`=2'b11);
  - the default `STABLE_CYCLES`.
- Sub-module `sync_2ff`: a generic two-flop synchronizer with the same `clk`/`rst` convention. It is reused for other asynchronous board inputs.
- The FSM and counter stay in `button_debouncer`.

## Test plan
All scenarios use `STABLE_CYCLES`=4 (latency 6 clocks).
- **Reset:** hold `rst`=0 for 3 clocks with `btn_in`=1 → `db_out`=0, `bouncing`=0 throughout. Release → `db_out` rises exactly 6 edges after the first edge with `rst`=1.
- **Clean press:** `btn_in` 0→1 before edge 10, held → `bouncing`=1 after edge 12, `db_out`=1 after edge 15, `bouncing`=0 after edge 15.
- **Bounce rejection:** `btn_in` high for 3 clocks, low for 1, high for 3, then low → `db_out` never leaves 0. `bouncing` toggles and ends 0.
- **Bounce then settle:** `btn_in` high 2 clocks, low 1, then high steady → `db_out` rises 6 clocks after the last 0→1 transition.
- **Release:** from `db_out`=1, `btn_in` 1→0 steady → `db_out` falls after exactly 6 clocks. Driving the edge detector with `db_out` yields exactly one `z` pulse per press.
- **Reset mid-check:** pull `rst`=0 for one edge while in `CHECK_HIGH` with `cnt`=2 → state `IDLE_LOW`, `cnt`=0, outputs 0 on the next cycle. Requalification needs a full 6 clocks.
